serializer: RTL



---
 rtl/serializer_pkg.sv | 18 +
 rtl/serializer_ctrl.sv | 102 ++++++++++
 rtl/serializer.sv | 58 +++++
 3 files changed

// File: rtl/serializer_pkg.sv
// serializer_pkg: shared types and sizing helpers for the serializer slice.
// Contents: FSM state enum (IDLE/SEND) and the counter width helper.
// Latency/backpressure: n/a (declarations only).
package serializer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_t;

  // Width of a counter that indexes 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serializer_ctrl.sv
// serializer_ctrl: IDLE/SEND FSM and word counter for the serializer.
// Latency: first word valid the cycle after frame accept; one word per send_val&send_rdy.
// Backpressure: count and state hold while send_rdy is low; recv_rdy only in IDLE
//   (or on the last-word cycle when SERIALIZER_OVERLAP_EN is defined).
// Ports: clk, reset (async active-low), recv_val/send_rdy in;
//        recv_rdy, send_val, count (buffer index), load_en (buffer write strobe) out.
module serializer_ctrl
  import serializer_pkg::*;
#(
  parameter int N_SAMPLES = 8,
  parameter int CNT_W     = cnt_width(N_SAMPLES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             recv_val,
  input  logic             send_rdy,
  output logic             recv_rdy,
  output logic             send_val,
  output logic [CNT_W-1:0] count,
  output logic             load_en
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_SAMPLES - 1);

  ser_state_t       r_state;
  ser_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             r_alive;
  logic             w_last;
  logic             w_xfer;

  // r_alive keeps recv_rdy low while reset is held; it rises on the first
  // edge after release so the block never advertises ready during reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_count <= '0;
      r_alive <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_alive <= 1'b1;
    end
  end

  assign w_last = (r_count == LAST);

  always_comb begin
    recv_rdy    = 1'b0;
    send_val    = 1'b0;
    w_xfer      = 1'b0;
    load_en     = 1'b0;
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    case (r_state)
      IDLE: begin
        recv_rdy = r_alive;
      end
      SEND: begin
        send_val = 1'b1;
`ifdef SERIALIZER_OVERLAP_EN
        // Take the next frame in the same cycle the last word leaves.
        recv_rdy = w_last & send_rdy;
`endif
      end
      default: begin
        recv_rdy = 1'b0;
      end
    endcase

    w_xfer  = send_val & send_rdy;
    load_en = recv_val & recv_rdy;

    case (r_state)
      IDLE: begin
        if (load_en) begin
          w_state_nxt = SEND;
          w_count_nxt = '0;
        end
      end
      SEND: begin
        if (w_xfer) begin
          if (w_last) begin
            w_count_nxt = '0;
            // load_en can only be high here in the overlap build.
            w_state_nxt = load_en ? SEND : IDLE;
          end else begin
            w_count_nxt = r_count + CNT_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_count_nxt = '0;
      end
    endcase
  end

  assign count = r_count;

endmodule

// File: rtl/serializer.sv
// serializer: buffers one N_SAMPLES-word frame and streams it out word 0 first.
// Latency: first word valid the cycle after frame accept; N_SAMPLES+1 cycles/frame
//   (N_SAMPLES with SERIALIZER_OVERLAP_EN defined and continuous traffic).
// Backpressure: send_msg/count hold while send_rdy is low; send_val never drops mid-frame.
// Ports: clk, reset (async active-low); recv_val/recv_rdy/recv_msg[N_SAMPLES] parallel in;
//        send_val/send_rdy/send_msg serial out. Option macro: SERIALIZER_OVERLAP_EN.
module serializer
  import serializer_pkg::*;
#(
  parameter int N_SAMPLES = 8,
  parameter int BIT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 recv_val,
  output logic                 recv_rdy,
  input  logic [BIT_WIDTH-1:0] recv_msg [N_SAMPLES-1:0],
  output logic                 send_val,
  input  logic                 send_rdy,
  output logic [BIT_WIDTH-1:0] send_msg
);

  localparam int CNT_W = cnt_width(N_SAMPLES);

  logic [CNT_W-1:0]     w_count;
  logic                 w_load_en;
  logic [BIT_WIDTH-1:0] r_buf [N_SAMPLES-1:0];

  serializer_ctrl #(
    .N_SAMPLES (N_SAMPLES),
    .CNT_W     (CNT_W)
  ) u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .recv_val (recv_val),
    .send_rdy (send_rdy),
    .recv_rdy (recv_rdy),
    .send_val (send_val),
    .count    (w_count),
    .load_en  (w_load_en)
  );

  // One enabled, reset-to-zero register per word; recv_msg is only
  // sampled on the accept edge.
  for (genvar g = 0; g < N_SAMPLES; g++) begin : g_buf
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_buf[g] <= '0;
      end else if (w_load_en) begin
        r_buf[g] <= recv_msg[g];
      end
    end
  end

  // Count never exceeds N_SAMPLES-1, so the mux index is always in range.
  assign send_msg = r_buf[w_count];

endmodule
